// File: rtl/pixel_dispatcher.sv
// Raster-order pixel scheduler: drives the coordinate mapper, then hands each mapped point to an engine round-robin.
// Define PIXEL_DISPATCHER_ABORT_EN to add the `abort` input that drops the current frame.
module pixel_dispatcher #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
`ifdef PIXEL_DISPATCHER_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic [10:0]            map_x,
    output logic [10:0]            map_y,
    input  logic [WORD_LENGTH-1:0] map_real,
    input  logic [WORD_LENGTH-1:0] map_imag,
    output logic [NUM_ENGINES-1:0] eng_valid,
    input  logic [NUM_ENGINES-1:0] eng_ready,
    output logic [WORD_LENGTH-1:0] eng_real,
    output logic [WORD_LENGTH-1:0] eng_imag,
    output logic [10:0]            eng_x,
    output logic [10:0]            eng_y
);

    localparam int unsigned CW = 11;
    localparam int unsigned PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [CW-1:0] X_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_LAST = CW'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DISPATCH,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [PW-1:0] r_rr_ptr;
    logic [CW-1:0] r_cur_x;
    logic [CW-1:0] r_cur_y;

    logic [PW-1:0] w_grant;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_rr_next;
    logic          w_any_ready;
    logic          w_handshake;
    logic          w_abort;
    logic          w_x_last;
    logic          w_y_last;
    logic [CW-1:0] w_next_x;
    logic [CW-1:0] w_next_y;

`ifdef PIXEL_DISPATCHER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // First ready engine at or above rr_ptr, wrapping modulo NUM_ENGINES.
    always_comb begin
        w_grant     = r_rr_ptr;
        w_idx       = '0;
        w_any_ready = 1'b0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            w_idx = PW'((32'(r_rr_ptr) + k) % NUM_ENGINES);
            if (!w_any_ready && eng_ready[w_idx]) begin
                w_any_ready = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    assign w_rr_next   = PW'((32'(w_grant) + 32'd1) % NUM_ENGINES);
    assign w_handshake = (r_state == S_DISPATCH) && w_any_ready;
    assign eng_valid   = w_handshake ? (NUM_ENGINES'(1) << w_grant) : '0;

    assign w_x_last = (r_cur_x == X_LAST);
    assign w_y_last = (r_cur_y == Y_LAST);
    assign w_next_x = w_x_last ? '0 : r_cur_x + CW'(1);
    assign w_next_y = w_x_last ? r_cur_y + CW'(1) : r_cur_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
            map_x      <= '0;
            map_y      <= '0;
            eng_real   <= '0;
            eng_imag   <= '0;
            eng_x      <= '0;
            eng_y      <= '0;
        end else begin
            frame_done <= 1'b0;
            // Abort wins over any same-edge handshake: rr_ptr and position stay put.
            if (w_abort && (r_state != S_IDLE)) begin
                r_state    <= S_IDLE;
                frame_busy <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_cur_x    <= '0;
                            r_cur_y    <= '0;
                            map_x      <= '0;
                            map_y      <= '0;
                            frame_busy <= 1'b1;
                            r_state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        eng_real <= map_real;
                        eng_imag <= map_imag;
                        eng_x    <= r_cur_x;
                        eng_y    <= r_cur_y;
                        r_state  <= S_DISPATCH;
                    end
                    S_DISPATCH: begin
                        if (w_any_ready) begin
                            r_rr_ptr <= w_rr_next;
                            if (w_x_last && w_y_last) begin
                                r_cur_x    <= '0;
                                r_cur_y    <= '0;
                                frame_done <= 1'b1;
                                r_state    <= S_DONE;
                            end else begin
                                r_cur_x <= w_next_x;
                                r_cur_y <= w_next_y;
                                map_x   <= w_next_x;
                                map_y   <= w_next_y;
                                r_state <= S_ISSUE;
                            end
                        end
                    end
                    S_DONE: begin
                        frame_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    default: begin
                        frame_busy <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Scoreboard bench for pixel_dispatcher: three instances (2x4x2, 4x4x2, 1x1x1 engines x H x V).
module tb_pixel_dispatcher;

    typedef struct packed {
        logic [3:0]  g;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    logic clk;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    event smp;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    logic        a_start, a_busy, a_done;
    logic [10:0] a_mx, a_my, a_ex, a_ey;
    logic [31:0] a_mr, a_mi, a_er, a_ei;
    logic [1:0]  a_valid, a_ready;

    logic        b_start, b_busy, b_done, b_abort;
    logic [10:0] b_mx, b_my, b_ex, b_ey;
    logic [31:0] b_mr, b_mi, b_er, b_ei;
    logic [3:0]  b_valid, b_ready;

    logic        c_start, c_busy, c_done;
    logic [10:0] c_mx, c_my, c_ex, c_ey;
    logic [31:0] c_mr, c_mi, c_er, c_ei;
    logic [0:0]  c_valid, c_ready;

    pixel_dispatcher #(.WORD_LENGTH(32), .NUM_ENGINES(2), .H_RES(4), .V_RES(2)) u_a (
        .clk(clk), .rst_n(rst_a), .start(a_start),
`ifdef PIXEL_DISPATCHER_ABORT_EN
        .abort(1'b0),
`endif
        .frame_busy(a_busy), .frame_done(a_done), .map_x(a_mx), .map_y(a_my),
        .map_real(a_mr), .map_imag(a_mi), .eng_valid(a_valid), .eng_ready(a_ready),
        .eng_real(a_er), .eng_imag(a_ei), .eng_x(a_ex), .eng_y(a_ey));

    pixel_dispatcher #(.WORD_LENGTH(32), .NUM_ENGINES(4), .H_RES(4), .V_RES(2)) u_b (
        .clk(clk), .rst_n(rst_b), .start(b_start),
`ifdef PIXEL_DISPATCHER_ABORT_EN
        .abort(b_abort),
`endif
        .frame_busy(b_busy), .frame_done(b_done), .map_x(b_mx), .map_y(b_my),
        .map_real(b_mr), .map_imag(b_mi), .eng_valid(b_valid), .eng_ready(b_ready),
        .eng_real(b_er), .eng_imag(b_ei), .eng_x(b_ex), .eng_y(b_ey));

    pixel_dispatcher #(.WORD_LENGTH(32), .NUM_ENGINES(1), .H_RES(1), .V_RES(1)) u_c (
        .clk(clk), .rst_n(rst_a), .start(c_start),
`ifdef PIXEL_DISPATCHER_ABORT_EN
        .abort(1'b0),
`endif
        .frame_busy(c_busy), .frame_done(c_done), .map_x(c_mx), .map_y(c_my),
        .map_real(c_mr), .map_imag(c_mi), .eng_valid(c_valid), .eng_ready(c_ready),
        .eng_real(c_er), .eng_imag(c_ei), .eng_x(c_ex), .eng_y(c_ey));

    // Registered mapper models: real = {x, y}, imag = {y, x}, one clock late.
    always @(posedge clk) begin
        a_mr <= 32'({a_mx, a_my});  a_mi <= 32'({a_my, a_mx});
        b_mr <= 32'({b_mx, b_my});  b_mi <= 32'({b_my, b_mx});
        c_mr <= 32'({c_mx, c_my});  c_mi <= 32'({c_my, c_mx});
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Sample point 1 time unit before each rising edge.
    initial forever begin
        @(negedge clk);
        #4;
        ->smp;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int g, input int x, input int y);
        return {4'(g), 11'(x), 11'(y)};
    endfunction

    task automatic hs_check(input string tag, input exp_t e, input logic [15:0] vld,
                            input logic [10:0] x, input logic [10:0] y,
                            input logic [31:0] re, input logic [31:0] im);
        logic [15:0] ev;
        ev = 16'(1) << e.g;
        chk({tag, "_grant"}, 32'(vld), 32'(ev));
        chk({tag, "_x"}, 32'(x), 32'(e.x));
        chk({tag, "_y"}, 32'(y), 32'(e.y));
        chk({tag, "_real"}, re, 32'({e.x, e.y}));
        chk({tag, "_imag"}, im, 32'({e.y, e.x}));
    endtask

    task automatic unexpected(input string tag, input logic [10:0] x, input logic [10:0] y);
        n_chk++;
        n_err++;
        $display("FAIL %s_unexpected_hs: handshake at x=%0d y=%0d, expected none", tag, x, y);
    endtask

    // Scoreboard monitors: pop one expectation per observed handshake.
    initial forever begin
        @(smp);
        if (rst_a && (|(a_valid & a_ready))) begin
            if (qa.size() == 0) unexpected("A", a_ex, a_ey);
            else hs_check("A", qa.pop_front(), 16'(a_valid), a_ex, a_ey, a_er, a_ei);
        end
    end

    initial forever begin
        @(smp);
        if (rst_b && !b_abort && (|(b_valid & b_ready))) begin
            if (qb.size() == 0) unexpected("B", b_ex, b_ey);
            else hs_check("B", qb.pop_front(), 16'(b_valid), b_ex, b_ey, b_er, b_ei);
        end
    end

    initial forever begin
        @(smp);
        if (rst_a && (|(c_valid & c_ready))) begin
            if (qc.size() == 0) unexpected("C", c_ex, c_ey);
            else hs_check("C", qc.pop_front(), 16'(c_valid), c_ex, c_ey, c_er, c_ei);
        end
    end

    function automatic logic done_of(input int d);
        case (d)
            0:       return a_done;
            1:       return b_done;
            default: return c_done;
        endcase
    endfunction

    function automatic logic busy_of(input int d);
        case (d)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       a_start = v;
            1:       b_start = v;
            default: c_start = v;
        endcase
    endtask

    // Returns the edge index s at which start was sampled.
    task automatic pulse_start(input int d, output int s);
        @(negedge clk);
        set_start(d, 1'b1);
        @(negedge clk);
        set_start(d, 1'b0);
        s = cyc;
        @(smp);
        chk("busy_after_start", 32'(busy_of(d)), 32'd1);
    endtask

    // span = cycles from the start cycle through the frame_done cycle, inclusive.
    task automatic wait_done(input int d, input int s, input int budget, output int span);
        bit got;
        got  = 1'b0;
        span = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(smp);
            if (done_of(d)) begin
                got  = 1'b1;
                span = cyc - s + 2;
            end
        end
        chk("frame_done_seen", 32'(got), 32'd1);
        if (got) begin
            @(smp);
            chk("busy_after_done", 32'(busy_of(d)), 32'd0);
            chk("done_one_cycle", 32'(done_of(d)), 32'd0);
        end
    endtask

    task automatic wait_hs_b(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(smp);
            if (rst_b && !b_abort && (|(b_valid & b_ready))) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL B_hs_timeout: no handshake within %0d cycles, expected one", budget);
        end
    endtask

    initial begin
        int s;
        int span;
        logic [3:0] pat [8];
        int         gnt [8];
        pat = '{4'b0100, 4'b0100, 4'b0001, 4'b1001, 4'b1001, 4'b1111, 4'b1111, 4'b0010};
        gnt = '{2, 2, 0, 3, 0, 1, 2, 1};

        rst_a = 1'b0; rst_b = 1'b0;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; b_abort = 1'b0;
        a_ready = 2'b11; b_ready = 4'b0100; c_ready = 1'b1;
        @(smp);
        chk("rst_busy", 32'({a_busy, b_busy, c_busy}), 32'd0);
        chk("rst_done", 32'({a_done, b_done, c_done}), 32'd0);
        chk("rst_valid", 32'({a_valid, b_valid, c_valid}), 32'd0);
        chk("rst_map", 32'({a_mx, a_my}), 32'd0);
        chk("rst_eng_tag", 32'({b_ex, b_ey}), 32'd0);
        chk("rst_eng_real", b_er | b_ei, 32'd0);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;

        // Basic frame on A: grants alternate 0,1; 3*8+2 cycle span.
        for (int p = 0; p < 8; p++) qa.push_back(mk(p % 2, p % 4, p / 4));
        pulse_start(0, s);
        wait_done(0, s, 60, span);
        chk("A_frame_span", 32'(span), 32'd26);

        // Single-pixel frame on C.
        qc.push_back(mk(0, 0, 0));
        pulse_start(2, s);
        wait_done(2, s, 20, span);
        chk("C_frame_span", 32'(span), 32'd5);

        // B: stall on pixel (1,0), then round-robin skip patterns.
        qb.push_back(mk(gnt[0], 0, 0));
        pulse_start(1, s);
        chk("B_latency_issue", 32'(b_valid), 32'd0);
        wait_hs_b(10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("B_stall_pre_valid", 32'(b_valid), 32'b0100);
        #1 b_ready = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(smp);
            chk("B_stall_valid", 32'(b_valid), 32'd0);
            chk("B_stall_tag", 32'({b_ex, b_ey}), 32'({11'd1, 11'd0}));
            chk("B_stall_real", b_er, 32'({11'd1, 11'd0}));
        end
        @(negedge clk);
        b_ready = pat[1];
        qb.push_back(mk(gnt[1], 1, 0));
        wait_hs_b(10);
        for (int p = 2; p < 8; p++) begin
            @(negedge clk);
            b_ready = pat[p];
            qb.push_back(mk(gnt[p], p % 4, p / 4));
            wait_hs_b(10);
        end
        wait_done(1, s, 10, span);

        // Reset mid-frame at pixel (2,0); rr_ptr is 2 entering this frame.
        @(negedge clk);
        b_ready = 4'b1111;
        qb.push_back(mk(2, 0, 0));
        qb.push_back(mk(3, 1, 0));
        pulse_start(1, s);
        wait_hs_b(10);
        wait_hs_b(10);
        @(negedge clk);
        b_ready = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("B_pre_reset_map_x", 32'(b_mx), 32'd2);
        chk("B_pre_reset_eng_x", 32'(b_ex), 32'd2);
        #1 rst_b = 1'b0;
        #1;
        chk("B_arst_busy_done", 32'({b_busy, b_done}), 32'd0);
        chk("B_arst_valid", 32'(b_valid), 32'd0);
        chk("B_arst_map", 32'({b_mx, b_my}), 32'd0);
        chk("B_arst_tag", 32'({b_ex, b_ey}), 32'd0);
        chk("B_arst_real", b_er | b_ei, 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        b_ready = 4'b1111;
        for (int p = 0; p < 8; p++) qb.push_back(mk(p % 4, p % 4, p / 4));
        pulse_start(1, s);
        wait_done(1, s, 60, span);
        chk("B_frame_span", 32'(span), 32'd26);

`ifdef PIXEL_DISPATCHER_ABORT_EN
        // Abort in CAPTURE.
        pulse_start(1, s);
        @(negedge clk);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        @(smp);
        chk("abort_cap_busy", 32'(b_busy), 32'd0);
        chk("abort_cap_valid", 32'(b_valid), 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(smp);
                seen = seen | b_done;
            end
            chk("abort_no_done", 32'(seen), 32'd0);
        end
        // Abort on a handshake edge: engine 0 is offered, must not count.
        pulse_start(1, s);
        @(negedge clk);
        @(negedge clk);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        @(smp);
        chk("abort_hs_busy", 32'(b_busy), 32'd0);
        // Abort with start in IDLE stays IDLE.
        @(negedge clk);
        b_start = 1'b1;
        b_abort = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_abort = 1'b0;
        @(smp);
        chk("abort_start_idle", 32'(b_busy), 32'd0);
        // rr_ptr was not advanced by the aborted offer.
        for (int p = 0; p < 8; p++) qb.push_back(mk(p % 4, p % 4, p / 4));
        pulse_start(1, s);
        wait_done(1, s, 60, span);
        chk("B_post_abort_span", 32'(span), 32'd26);
`endif

        @(smp);
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        chk("qc_drained", 32'(qc.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
